// File: rtl/wm_trigger_sequencer.sv
// Round-robin sequencer feeding one requester's 64-bit key serially into the watermark core.
// Optional requester lockout is built when WM_SEQ_LOCKOUT_EN is defined.
module wm_trigger_sequencer #(
  parameter int N_REQ      = 3,
  parameter int TIMEOUT    = 4,
  parameter int LOCK_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*64-1:0]   key,
  output logic [N_REQ-1:0]      done,
  output logic                  match,
  output logic [63:0]           sig_out,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [N_REQ-1:0]      locked,
  output logic                  tr_we,
  output logic                  tr_bit,
  input  logic                  sig_valid,
  input  logic [63:0]           sig_value
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255 ||
      LOCK_LIMIT < 1 || LOCK_LIMIT > 255) begin : g_cfg_check
    $error("wm_trigger_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [2:0]       r_ptr;
  logic [2:0]       r_grant;
  logic [63:0]      r_shift;
  logic [5:0]       r_bit_cnt;
  logic [7:0]       r_wait_cnt;
  logic             r_match;
  logic [63:0]      r_sig;

  logic [N_REQ-1:0] w_elig;
  logic             w_any;
  logic [2:0]       w_winner;
  logic [2:0]       w_ptr_next;
  logic [63:0]      w_key_sel;
  logic             w_wait_last;

  assign w_elig      = req & ~locked;
  assign w_wait_last = (r_wait_cnt == 8'(TIMEOUT - 1));
  assign w_ptr_next  = (w_winner == 3'(N_REQ - 1)) ? 3'd0 : w_winner + 3'd1;

  // Two passes: first eligible index at/after the pointer, else first below it (wrap).
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_any && w_elig[i] && (3'(i) >= r_ptr)) begin
        w_any    = 1'b1;
        w_winner = 3'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_any && w_elig[i] && (3'(i) < r_ptr)) begin
        w_any    = 1'b1;
        w_winner = 3'(i);
      end
    end
  end

  always_comb begin
    w_key_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_key_sel = key[64*i +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_SHIFT;
      S_SHIFT: if (r_bit_cnt == 6'd63) w_next = S_WAIT;
      S_WAIT:  if (sig_valid || w_wait_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_match    <= 1'b0;
      r_sig      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_shift    <= w_key_sel;
            r_grant    <= w_winner;
            r_ptr      <= w_ptr_next;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_shift   <= {r_shift[62:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end
        S_WAIT: begin
          // A strobe on the final wait cycle still counts as a match.
          if (sig_valid) begin
            r_match    <= 1'b1;
            r_sig      <= sig_value;
            r_wait_cnt <= '0;
          end else if (w_wait_last) begin
            r_match    <= 1'b0;
            r_sig      <= '0;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    tr_we    = (r_state == S_SHIFT);
    tr_bit   = (r_state == S_SHIFT) && r_shift[63];
    match    = r_match;
    sig_out  = r_sig;
    grant_id = r_grant;
    done     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      done[i] = (r_state == S_DONE) && (r_grant == 3'(i));
    end
  end

`ifdef WM_SEQ_LOCKOUT_EN
  logic [7:0] r_fail [N_REQ];

  // Counter is updated at the end of DONE, so the lock shows the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        r_fail[i] <= '0;
      end
    end else if (r_state == S_DONE) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (r_grant == 3'(i)) begin
          if (r_match) begin
            r_fail[i] <= '0;
          end else if (r_fail[i] < 8'(LOCK_LIMIT)) begin
            r_fail[i] <= r_fail[i] + 8'd1;
          end
        end
      end
    end
  end

  always_comb begin
    locked = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      locked[i] = (r_fail[i] >= 8'(LOCK_LIMIT));
    end
  end
`else
  assign locked = '0;
`endif

endmodule

// File: tb/tb_wm_trigger_sequencer.sv
// Testbench for wm_trigger_sequencer with a behavioural watermark core and round-robin reference model.
module tb_wm_trigger_sequencer;
  localparam int N     = 3;
  localparam int TO    = 4;
  localparam int LL    = 3;
  localparam int LAT_M = 66;
  localparam int LAT_F = 65 + TO;
  localparam logic [63:0] MAGIC = 64'hA5A5_0F0F_1234_5678;
  localparam logic [63:0] SIGN  = 64'hDEAD_BEEF_CAFE_F00D;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*64-1:0] key;
  logic [N-1:0]    done;
  logic            match;
  logic [63:0]     sig_out;
  logic            busy;
  logic [2:0]      grant_id;
  logic [N-1:0]    locked;
  logic            tr_we;
  logic            tr_bit;
  logic            sig_valid;
  logic [63:0]     sig_value;

  always #5 clk = ~clk;

  wm_trigger_sequencer #(.N_REQ(N), .TIMEOUT(TO), .LOCK_LIMIT(LL)) dut (
    .clk(clk), .rst(rst), .req(req), .key(key), .done(done), .match(match),
    .sig_out(sig_out), .busy(busy), .grant_id(grant_id), .locked(locked),
    .tr_we(tr_we), .tr_bit(tr_bit), .sig_valid(sig_valid), .sig_value(sig_value)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: collects serial bits, strobes the signature the cycle after shifting stops.
  logic        core_sv = 1'b0;
  logic        stray_sv;
  logic [63:0] stray_val;
  logic [63:0] hist;
  logic        prev_we;
  assign sig_valid = core_sv | stray_sv;
  assign sig_value = core_sv ? SIGN : stray_val;

  initial begin
    hist    = '0;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      core_sv = 1'b0;
      if (tr_we) begin
        hist    = {hist[62:0], tr_bit};
        prev_we = 1'b1;
      end else begin
        if (prev_we && hist == MAGIC) core_sv = 1'b1;
        prev_we = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: round-robin pointer and per-requester failure counts.
  int m_ptr;
  int m_fail [N];

  function automatic logic [N-1:0] m_locked();
    logic [N-1:0] l = '0;
`ifdef WM_SEQ_LOCKOUT_EN
    for (int i = 0; i < N; i++) if (m_fail[i] >= LL) l[i] = 1'b1;
`endif
    return l;
  endfunction

  function automatic int m_pick(input logic [N-1:0] r);
    logic [N-1:0] e = r & ~m_locked();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (e[i]) begin
        m_ptr = (i + 1) % N;
        return i;
      end
    end
    return -1;
  endfunction

  function automatic void m_done(input int w, input bit hit);
    if (hit) m_fail[w] = 0;
    else if (m_fail[w] < LL) m_fail[w] = m_fail[w] + 1;
  endfunction

  function automatic logic [63:0] rnd_key();
    logic [63:0] k = {$urandom, $urandom};
    if (k == MAGIC) k = ~k;
    return k;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_fail[i] = 0;
  endtask

  task automatic wait_done(input int budget, output int dc, output logic [N-1:0] dv);
    dc = -1;
    dv = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != '0) begin
        dc = cyc;
        dv = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (done     !== '0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (match    !== 1'b0) begin bad++; $display("FAIL reset_match: got %b want 0", match); end
    total++; if (sig_out  !== '0)   begin bad++; $display("FAIL reset_sig: got %h want 0", sig_out); end
    total++; if (busy     !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    total++; if (locked   !== '0)   begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (tr_we    !== 1'b0) begin bad++; $display("FAIL reset_tr_we: got %b want 0", tr_we); end
    total++; if (tr_bit   !== 1'b0) begin bad++; $display("FAIL reset_tr_bit: got %b want 0", tr_bit); end
  endtask

  task automatic test_single_match();
    logic [63:0]  kk = MAGIC;
    logic [N-1:0] ed;
    logic         ewe;
    int           w;
    @(negedge clk);
    key[64 +: 64] = MAGIC;
    req[1] = 1'b1;
    w = m_pick(req);
    for (int c = 0; c <= LAT_M; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) key[64 +: 64] = rnd_key();
      ewe = (c >= 1 && c <= 64);
      ed  = (c == LAT_M) ? 3'b010 : 3'b000;
      total++; if (tr_we !== ewe) begin bad++; $display("FAIL single_tr_we c=%0d: got %b want %b", c, tr_we, ewe); end
      if (ewe) begin
        total++; if (tr_bit !== kk[64-c]) begin bad++; $display("FAIL single_tr_bit c=%0d: got %b want %b", c, tr_bit, kk[64-c]); end
      end
      total++; if (busy !== (c >= 1)) begin bad++; $display("FAIL single_busy c=%0d: got %b want %b", c, busy, c >= 1); end
      total++; if (done !== ed) begin bad++; $display("FAIL single_done c=%0d: got %b want %b", c, done, ed); end
    end
    total++; if (match    !== 1'b1) begin bad++; $display("FAIL single_match: got %b want 1", match); end
    total++; if (sig_out  !== SIGN) begin bad++; $display("FAIL single_sig: got %h want %h", sig_out, SIGN); end
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL single_grant: got %0d want 1", grant_id); end
    req[1] = 1'b0;
    m_done(w, 1'b1);
  endtask

  task automatic test_wrong_key();
    logic [N-1:0] ed;
    logic         em;
    logic [63:0]  es;
    int           w;
    @(negedge clk);
    key[0 +: 64] = '0;
    req[0] = 1'b1;
    w = m_pick(req);
    for (int c = 1; c <= LAT_F + 5; c++) begin
      @(negedge clk);
      ed = (c == LAT_F) ? 3'b001 : 3'b000;
      em = (c < LAT_F);
      es = em ? SIGN : 64'd0;
      total++; if (done    !== ed) begin bad++; $display("FAIL wrong_done c=%0d: got %b want %b", c, done, ed); end
      total++; if (match   !== em) begin bad++; $display("FAIL wrong_match c=%0d: got %b want %b", c, match, em); end
      total++; if (sig_out !== es) begin bad++; $display("FAIL wrong_sig c=%0d: got %h want %h", c, sig_out, es); end
      if (c == LAT_F) begin
        req[0] = 1'b0;
        m_done(w, 1'b0);
      end
    end
  endtask

  task automatic test_stray();
    logic [N-1:0] ed;
    int           w;
    @(negedge clk);
    stray_val = rnd_key();
    stray_sv  = 1'b1;
    @(negedge clk);
    stray_sv = 1'b0;
    total++; if (done    !== '0)   begin bad++; $display("FAIL stray_idle_done: got %b want 0", done); end
    total++; if (busy    !== 1'b0) begin bad++; $display("FAIL stray_idle_busy: got %b want 0", busy); end
    total++; if (match   !== 1'b0) begin bad++; $display("FAIL stray_idle_match: got %b want 0", match); end
    total++; if (sig_out !== '0)   begin bad++; $display("FAIL stray_idle_sig: got %h want 0", sig_out); end
    key[128 +: 64] = rnd_key();
    req = 3'b100;
    w = m_pick(req);
    for (int c = 1; c <= LAT_F; c++) begin
      @(negedge clk);
      stray_sv  = (c == 20);
      stray_val = rnd_key();
      ed = (c == LAT_F) ? 3'b100 : 3'b000;
      total++; if (done    !== ed)   begin bad++; $display("FAIL stray_done c=%0d: got %b want %b", c, done, ed); end
      total++; if (match   !== 1'b0) begin bad++; $display("FAIL stray_match c=%0d: got %b want 0", c, match); end
      total++; if (sig_out !== '0)   begin bad++; $display("FAIL stray_sig c=%0d: got %h want 0", c, sig_out); end
    end
    stray_sv = 1'b0;
    req = '0;
    m_done(w, 1'b0);
  endtask

  task automatic test_arbitration();
    int           ord [4] = '{0, 1, 2, 0};
    int           s, dc, w;
    logic [N-1:0] dv, ev;
    apply_reset();
    for (int i = 0; i < N; i++) key[64*i +: 64] = rnd_key();
    @(negedge clk);
    req = 3'b111;
    s = cyc;
    for (int k = 0; k < 4; k++) begin
      w  = m_pick(req);
      ev = '0;
      ev[ord[k]] = 1'b1;
      wait_done(200, dc, dv);
      total++; if (dv !== ev) begin bad++; $display("FAIL arb_order k=%0d: got %b want %b", k, dv, ev); end
      total++; if (dc !== s + LAT_F) begin bad++; $display("FAIL arb_latency k=%0d: got %0d want %0d", k, dc - s, LAT_F); end
      total++; if (grant_id !== 3'(ord[k])) begin bad++; $display("FAIL arb_grant k=%0d: got %0d want %0d", k, grant_id, ord[k]); end
      req[ord[k]] = 1'b0;
      if (w >= 0) m_done(w, 1'b0);
      s = dc + 1;
      if (k == 0) begin
        @(negedge clk);
        req[0] = 1'b1;
      end
    end
    req = '0;
  endtask

  task automatic test_mid_attempt();
    int           s, dc, w, seen;
    logic [N-1:0] dv;
    @(negedge clk);
    key[128 +: 64] = rnd_key();
    req = 3'b100;
    s = cyc;
    w = m_pick(req);
    repeat (30) @(negedge clk);
    req[2] = 1'b0;
    wait_done(100, dc, dv);
    total++; if (dv !== 3'b100) begin bad++; $display("FAIL drop_done: got %b want 100", dv); end
    total++; if (dc !== s + LAT_F) begin bad++; $display("FAIL drop_latency: got %0d want %0d", dc - s, LAT_F); end
    m_done(w, 1'b0);
    @(negedge clk);
    key[64 +: 64] = rnd_key();
    req = 3'b010;
    w = m_pick(req);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (tr_we !== 1'b0) begin bad++; $display("FAIL rstmid_tr_we: got %b want 0", tr_we); end
    total++; if (busy  !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst   = 1'b0;
    req   = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_fail[i] = 0;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done != '0 || tr_we) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_activity: got %0d active cycles want 0", seen); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL rstmid_grant: got %0d want 0", grant_id); end
  endtask

  task automatic test_lockout();
    int           s, dc, w;
    logic [N-1:0] dv, el;
    apply_reset();
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      key[0 +: 64] = rnd_key();
      req = 3'b001;
      s = cyc;
      w = m_pick(req);
      wait_done(200, dc, dv);
      total++; if (dv !== 3'b001) begin bad++; $display("FAIL lock_attempt a=%0d: got %b want 001", a, dv); end
      total++; if (dc !== s + LAT_F) begin bad++; $display("FAIL lock_latency a=%0d: got %0d want %0d", a, dc - s, LAT_F); end
      req = '0;
      m_done(w, 1'b0);
    end
    total++; if (locked !== '0) begin bad++; $display("FAIL lock_early: got %b want 0", locked); end
    @(negedge clk);
    el = m_locked();
    total++; if (locked !== el) begin bad++; $display("FAIL lock_status: got %b want %b", locked, el); end
    key[64 +: 64] = rnd_key();
    req = 3'b011;
    s = cyc;
    w = m_pick(req);
    wait_done(200, dc, dv);
    total++; if (dv !== 3'b010) begin bad++; $display("FAIL lock_other_served: got %b want 010", dv); end
    total++; if (dc !== s + LAT_F) begin bad++; $display("FAIL lock_other_latency: got %0d want %0d", dc - s, LAT_F); end
    req[1] = 1'b0;
    m_done(w, 1'b0);
    s = dc + 1;
    wait_done(150, dc, dv);
`ifdef WM_SEQ_LOCKOUT_EN
    total++; if (dc !== -1) begin bad++; $display("FAIL lock_masked: got done %b at +%0d want none", dv, dc - s); end
`else
    total++; if (dv !== 3'b001) begin bad++; $display("FAIL lock_disabled_served: got %b want 001", dv); end
    total++; if (dc !== s + LAT_F) begin bad++; $display("FAIL lock_disabled_latency: got %0d want %0d", dc - s, LAT_F); end
    w = m_pick(3'b001);
    m_done(w, 1'b0);
`endif
    req = '0;
  endtask

  task automatic test_random();
    int           s, dc, w;
    logic [N-1:0] pend, dv, ev;
    bit           hit [N];
    logic [63:0]  es;
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        key[64*i +: 64] = ($urandom_range(0, 2) == 0) ? MAGIC : rnd_key();
        hit[i] = (key[64*i +: 64] == MAGIC);
      end
      pend = N'($urandom_range(1, (1 << N) - 1));
      req  = pend;
      s    = cyc;
      forever begin
        w = m_pick(pend);
        if (w < 0) break;
        ev = '0;
        ev[w] = 1'b1;
        es = hit[w] ? SIGN : 64'd0;
        wait_done(200, dc, dv);
        total++; if (dv !== ev) begin bad++; $display("FAIL rnd_done r=%0d: got %b want %b", r, dv, ev); end
        total++; if (dc !== s + (hit[w] ? LAT_M : LAT_F)) begin bad++; $display("FAIL rnd_latency r=%0d: got %0d want %0d", r, dc - s, hit[w] ? LAT_M : LAT_F); end
        total++; if (match !== hit[w]) begin bad++; $display("FAIL rnd_match r=%0d: got %b want %b", r, match, hit[w]); end
        total++; if (sig_out !== es) begin bad++; $display("FAIL rnd_sig r=%0d: got %h want %h", r, sig_out, es); end
        pend[w] = 1'b0;
        req[w]  = 1'b0;
        m_done(w, hit[w]);
        s = dc + 1;
      end
      req = '0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    key       = '0;
    stray_sv  = 1'b0;
    stray_val = '0;
    m_ptr     = 0;
    for (int i = 0; i < N; i++) m_fail[i] = 0;
    test_reset();
    test_single_match();
    test_wrong_key();
    test_stray();
    test_arbitration();
    test_mid_attempt();
    test_lockout();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wm_trigger_sequencer.md
# wm_trigger_sequencer

Sequencer and arbiter for the watermark proof core's serial trigger port. Several requesters (debug host, JTAG bridge, BIST) each present a 64-bit candidate key. The block grants one requester at a time round-robin, shifts its key serially into the core, waits a bounded time for the signature strobe, and returns match/signature to that requester. It sits between the requesters and the single watermark core, which is the only consumer of `tr_we`/`tr_bit`.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `TIMEOUT`, 4: cycles spent in WAIT before declaring no match (1..255).
- `LOCK_LIMIT`, 3: consecutive failures that lock out a requester; used only with the lockout macro.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request per requester; held until that requester's `done` bit.
- `key` in N_REQ*64: requester i's key is `key[64*i+63 : 64*i]`; must be stable while `req[i]` is high.
- `done` out N_REQ: one-cycle completion pulse to the served requester.
- `match` out 1: result of the last completed attempt; valid while `done` is high and held afterwards.
- `sig_out` out 64: signature captured on match, 0 on no-match; held like `match`.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 3: index of the current or last served requester.
- `locked` out N_REQ: lockout status per requester.
- `tr_we` out 1: to core, shift enable.
- `tr_bit` out 1: to core, serial bit.
- `sig_valid` in 1: from core, signature strobe.
- `sig_value` in 64: from core, signature.

## Operation
- FSM states:
  - IDLE: wait for an eligible request.
  - SHIFT: 64 cycles.
  - WAIT: up to TIMEOUT cycles.
  - DONE: 1 cycle.
- IDLE to SHIFT: when any eligible `req` is high.
  - Winner is the first high bit at or after the round-robin pointer, wrapping.
  - Winner's key is latched into a 64-bit shift register; `grant_id` is updated.
  - Pointer becomes winner+1 mod N_REQ. It is 0 after reset.
- SHIFT:
  - `tr_we`=1, `tr_bit` = key MSB first (key[63] first, key[0] last).
  - A 6-bit bit counter runs 0..63. At 63 go to WAIT.
  - All 64 bits are always sent, so stale core history is fully flushed.
- WAIT:
  - `tr_we`=0. The wait counter increments each cycle.
  - `sig_valid`=1: capture `sig_value`, set match=1, go to DONE.
  - Counter reaches TIMEOUT-1 without `sig_valid`: match=0, sig_out=0, go to DONE.
  - `sig_valid` outside WAIT is ignored.
- DONE:
  - `done[grant_id]`=1 and `match`/`sig_out` are updated.
  - Next state is IDLE. A request already pending is granted only from IDLE, so there is at least one IDLE cycle between attempts.
- Request rules:
  - Dropping `req` mid-attempt does not abort; the attempt completes and `done` is still pulsed.
  - Key changes after the IDLE latch cycle have no effect.
- Reset mid-operation: FSM goes to IDLE; `tr_we` is 0 from the next cycle; no `done` is issued; the core's partial shift is harmless because the next attempt flushes it.

## Timing
- Reset values: `done`=0, `match`=0, `sig_out`=0, `busy`=0, `grant_id`=0, `locked`=0, `tr_we`=0, `tr_bit`=0; pointer 0; all counters 0.
- Cycle numbering: let cycle 0 be the IDLE cycle in which `req` is sampled.
  - Cycles 1–64: `tr_we`=1.
  - The core asserts `sig_valid` in cycle 65; WAIT samples it in cycle 65.
  - DONE is cycle 66, so a matching attempt completes 66 cycles after request sampling.
- Timeout attempt: WAIT spans cycles 65..64+TIMEOUT; DONE at 65+TIMEOUT (69 at default).
- `busy` is high from cycle 1 through DONE inclusive.

## Configuration
Macro `WM_SEQ_LOCKOUT_EN` controls requester lockout.
- Defined:
  - Each requester has a saturating fail counter.
  - The counter increments on a no-match DONE for that requester and clears on a match DONE.
  - When it reaches LOCK_LIMIT, `locked[i]`=1 and `req[i]` is masked from arbitration until `rst`.
  - The lockout comparison uses the post-update counter, so `locked[i]` rises in the cycle after the LOCK_LIMIT-th failing DONE.
- Undefined:
  - No counters are built; `locked` is tied to 0.
  - Every request stays eligible indefinitely.

## Test plan
- Single match: core magic = key `64'hA5A5_0F0F_1234_5678` on req[1] → `tr_we` high cycles 1–64, MSB first; `done[1]` at cycle 66, `match`=1, `sig_out`=core SIGN.
- Wrong key: req[0] key 0 → `done[0]` at cycle 69, `match`=0, `sig_out`=0; `match`/`sig_out` held until the next DONE.
- Arbitration: req[0], req[1], req[2] all high at once from reset → served in order 0, 1, 2. With req[0] re-raised after its done and req[2] still pending, the order is 2 then 0.
- Mid-attempt: drop req[2] at cycle 30 → attempt still completes with `done[2]`. Separately, assert `rst` at cycle 30 of another attempt → `tr_we`=0 next cycle, no `done`, and `busy`=0.
- Lockout with `WM_SEQ_LOCKOUT_EN`: three wrong keys from req[0] → `locked[0]`=1 and a further req[0] gets no grant while req[1] is still served. Without the macro: `locked`=0 and req[0] keeps being served.
- Stray strobe: pulse `sig_valid` in IDLE and during SHIFT → no `done`, and `match`/`sig_out` unchanged.
